// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared frame states, scancode constants and Hack special-key codes
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] HK_NEWLINE   = 8'd128;
  localparam logic [7:0] HK_BACKSPACE = 8'd129;
  localparam logic [7:0] HK_LEFT      = 8'd130;
  localparam logic [7:0] HK_UP        = 8'd131;
  localparam logic [7:0] HK_RIGHT     = 8'd132;
  localparam logic [7:0] HK_DOWN      = 8'd133;
  localparam logic [7:0] HK_HOME      = 8'd134;
  localparam logic [7:0] HK_END       = 8'd135;
  localparam logic [7:0] HK_PGUP      = 8'd136;
  localparam logic [7:0] HK_PGDN      = 8'd137;
  localparam logic [7:0] HK_INSERT    = 8'd138;
  localparam logic [7:0] HK_DELETE    = 8'd139;
  localparam logic [7:0] HK_ESC       = 8'd140;
  localparam logic [7:0] HK_F1        = 8'd141;
  localparam logic [7:0] HK_F12       = 8'd152;

  function automatic logic isShiftKey(input logic [7:0] sc);
    return (sc == SC_LSHIFT) || (sc == SC_RSHIFT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_keymap.sv
// ============================================================================
// Module   : ps2_keymap
// Purpose  : Combinational Set-2 scancode to Hack keycode lookup
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keymap
  import ps2_pkg::*;
(
  input  logic       iExt,
  input  logic       iShift,
  input  logic       iCaps,
  input  logic [7:0] iScan,
  output logic       oValid,
  output logic [7:0] oCode
);

  logic       w_upper;
  logic [7:0] w_letter;
  logic [7:0] w_symLo;
  logic [7:0] w_symHi;
  logic [7:0] w_plain;
  logic [7:0] w_extCode;

  assign w_upper = iShift ^ iCaps;

  always_comb begin
    w_letter  = 8'h00;
    w_symLo   = 8'h00;
    w_symHi   = 8'h00;
    w_plain   = 8'h00;
    w_extCode = 8'h00;
    case (iScan)
      8'h1C: w_letter = 8'h61;
      8'h32: w_letter = 8'h62;
      8'h21: w_letter = 8'h63;
      8'h23: w_letter = 8'h64;
      8'h24: w_letter = 8'h65;
      8'h2B: w_letter = 8'h66;
      8'h34: w_letter = 8'h67;
      8'h33: w_letter = 8'h68;
      8'h43: w_letter = 8'h69;
      8'h3B: w_letter = 8'h6A;
      8'h42: w_letter = 8'h6B;
      8'h4B: w_letter = 8'h6C;
      8'h3A: w_letter = 8'h6D;
      8'h31: w_letter = 8'h6E;
      8'h44: w_letter = 8'h6F;
      8'h4D: w_letter = 8'h70;
      8'h15: w_letter = 8'h71;
      8'h2D: w_letter = 8'h72;
      8'h1B: w_letter = 8'h73;
      8'h2C: w_letter = 8'h74;
      8'h3C: w_letter = 8'h75;
      8'h2A: w_letter = 8'h76;
      8'h1D: w_letter = 8'h77;
      8'h22: w_letter = 8'h78;
      8'h35: w_letter = 8'h79;
      8'h1A: w_letter = 8'h7A;
      8'h16: {w_symLo, w_symHi} = {8'h31, 8'h21};
      8'h1E: {w_symLo, w_symHi} = {8'h32, 8'h40};
      8'h26: {w_symLo, w_symHi} = {8'h33, 8'h23};
      8'h25: {w_symLo, w_symHi} = {8'h34, 8'h24};
      8'h2E: {w_symLo, w_symHi} = {8'h35, 8'h25};
      8'h36: {w_symLo, w_symHi} = {8'h36, 8'h5E};
      8'h3D: {w_symLo, w_symHi} = {8'h37, 8'h26};
      8'h3E: {w_symLo, w_symHi} = {8'h38, 8'h2A};
      8'h46: {w_symLo, w_symHi} = {8'h39, 8'h28};
      8'h45: {w_symLo, w_symHi} = {8'h30, 8'h29};
      8'h0E: {w_symLo, w_symHi} = {8'h60, 8'h7E};
      8'h4E: {w_symLo, w_symHi} = {8'h2D, 8'h5F};
      8'h55: {w_symLo, w_symHi} = {8'h3D, 8'h2B};
      8'h54: {w_symLo, w_symHi} = {8'h5B, 8'h7B};
      8'h5B: {w_symLo, w_symHi} = {8'h5D, 8'h7D};
      8'h5D: {w_symLo, w_symHi} = {8'h5C, 8'h7C};
      8'h4C: {w_symLo, w_symHi} = {8'h3B, 8'h3A};
      8'h52: {w_symLo, w_symHi} = {8'h27, 8'h22};
      8'h41: {w_symLo, w_symHi} = {8'h2C, 8'h3C};
      8'h49: {w_symLo, w_symHi} = {8'h2E, 8'h3E};
      8'h4A: {w_symLo, w_symHi} = {8'h2F, 8'h3F};
      8'h29: {w_symLo, w_symHi} = {8'h20, 8'h20};
      8'h5A: w_plain = HK_NEWLINE;
      8'h66: w_plain = HK_BACKSPACE;
      8'h76: w_plain = HK_ESC;
      8'h05: w_plain = HK_F1;
      8'h06: w_plain = HK_F1 + 8'd1;
      8'h04: w_plain = HK_F1 + 8'd2;
      8'h0C: w_plain = HK_F1 + 8'd3;
      8'h03: w_plain = HK_F1 + 8'd4;
      8'h0B: w_plain = HK_F1 + 8'd5;
      8'h83: w_plain = HK_F1 + 8'd6;
      8'h0A: w_plain = HK_F1 + 8'd7;
      8'h01: w_plain = HK_F1 + 8'd8;
      8'h09: w_plain = HK_F1 + 8'd9;
      8'h78: w_plain = HK_F1 + 8'd10;
      8'h07: w_plain = HK_F12;
      default: ;
    endcase
    // Navigation block only exists behind the E0 prefix; bare codes are keypad
    case (iScan)
      8'h6B: w_extCode = HK_LEFT;
      8'h75: w_extCode = HK_UP;
      8'h74: w_extCode = HK_RIGHT;
      8'h72: w_extCode = HK_DOWN;
      8'h6C: w_extCode = HK_HOME;
      8'h69: w_extCode = HK_END;
      8'h7D: w_extCode = HK_PGUP;
      8'h7A: w_extCode = HK_PGDN;
      8'h70: w_extCode = HK_INSERT;
      8'h71: w_extCode = HK_DELETE;
      default: ;
    endcase
  end

  always_comb begin
    oCode = 8'h00;
    if (iExt)
      oCode = w_extCode;
    else if (w_letter != 8'h00)
      oCode = w_upper ? (w_letter - 8'h20) : w_letter;
    else if (w_symLo != 8'h00)
      oCode = iShift ? w_symHi : w_symLo;
    else
      oCode = w_plain;
    oValid = (oCode != 8'h00);
  end

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard.sv
// ============================================================================
// Module   : ps2_keyboard
// Purpose  : PS/2 Set-2 receiver producing the Hack keycode of the held key.
//            Optional Caps Lock tracking via macro PS2_CAPSLOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iPS2_CLK,
  input  logic        iPS2_DAT,
  output logic [15:0] oKBD,
  output logic        oERR
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    r_clkSync;
  logic [1:0]    r_datSync;
  logic          r_clkFilt;
  logic [FW-1:0] r_filtCnt;
  logic          w_clkRaw;
  logic          w_dat;
  logic          w_flip;
  logic          w_strobe;

  assign w_clkRaw = r_clkSync[1];
  assign w_dat    = r_datSync[1];
  assign w_flip   = (w_clkRaw != r_clkFilt) && (r_filtCnt == FW'(FILTER_LEN - 1));
  assign w_strobe = w_flip && r_clkFilt;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
      r_clkFilt <= 1'b1;
      r_filtCnt <= '0;
    end else begin
      r_clkSync <= {r_clkSync[0], iPS2_CLK};
      r_datSync <= {r_datSync[0], iPS2_DAT};
      // Count consecutive samples disagreeing with the filtered level
      if (w_clkRaw == r_clkFilt) begin
        r_filtCnt <= '0;
      end else if (w_flip) begin
        r_clkFilt <= w_clkRaw;
        r_filtCnt <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + FW'(1);
      end
    end
  end

  ps2State_e     r_state;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shiftReg;
  logic          r_parity;
  logic [TW-1:0] r_toCnt;
  logic          r_err;
  logic          w_stopGood;
  logic          w_byteValid;
  logic          w_timeout;

  assign w_stopGood  = w_dat && ((^r_shiftReg) ^ r_parity);
  assign w_byteValid = w_strobe && (r_state == STOP) && w_stopGood;
  assign w_timeout   = (r_state != IDLE) && !w_strobe && (r_toCnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state    <= IDLE;
      r_bitCnt   <= 3'd0;
      r_shiftReg <= 8'h00;
      r_parity   <= 1'b0;
      r_toCnt    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == IDLE || w_strobe)
        r_toCnt <= '0;
      else
        r_toCnt <= r_toCnt + TW'(1);

      if (w_timeout) begin
        r_state <= IDLE;
        r_err   <= 1'b1;
      end else if (w_strobe) begin
        case (r_state)
          IDLE: begin
            if (!w_dat) begin
              r_state  <= DATA;
              r_bitCnt <= 3'd0;
            end
          end
          DATA: begin
            r_shiftReg <= {w_dat, r_shiftReg[7:1]};
            r_bitCnt   <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7)
              r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= w_dat;
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (!w_stopGood)
              r_err <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  logic       r_shift;
  logic       r_ext;
  logic       r_brk;
  logic [7:0] r_kbd;
  logic [8:0] r_heldKey;
  logic       w_caps;
  logic       w_keyValid;
  logic [7:0] w_keyCode;

`ifdef PS2_CAPSLOCK_EN
  logic r_caps;
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)
      r_caps <= 1'b0;
    else if (w_byteValid && r_shiftReg == SC_CAPS && !r_brk)
      r_caps <= !r_caps;
  end
  assign w_caps = r_caps;
`else
  assign w_caps = 1'b0;
`endif

  ps2_keymap u_keymap (
    .iExt   (r_ext),
    .iShift (r_shift),
    .iCaps  (w_caps),
    .iScan  (r_shiftReg),
    .oValid (w_keyValid),
    .oCode  (w_keyCode)
  );

  // The held key is remembered by scancode so its break clears oKBD even
  // when shift changed between make and break.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_shift   <= 1'b0;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_kbd     <= 8'h00;
      r_heldKey <= 9'h000;
    end else if (w_byteValid) begin
      if (r_shiftReg == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (r_shiftReg == SC_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (isShiftKey(r_shiftReg)) begin
          r_shift <= !r_brk;
        end else if (!r_brk) begin
          if (w_keyValid) begin
            r_kbd     <= w_keyCode;
            r_heldKey <= {r_ext, r_shiftReg};
          end
        end else if (r_kbd != 8'h00 && r_heldKey == {r_ext, r_shiftReg}) begin
          r_kbd <= 8'h00;
        end
      end
    end
  end

  assign oKBD = {8'h00, r_kbd};
  assign oERR = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
// ============================================================================
// Module   : tb_ps2_keyboard
// Purpose  : Self-checking bench for ps2_keyboard with a table-driven key model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_keyboard;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 20;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        ps2Clk = 1'b1;
  logic        ps2Dat = 1'b1;
  logic [15:0] kbd;
  logic        err;

  int nChecks   = 0;
  int nFails    = 0;
  int errPulses = 0;
  int errWide   = 0;
  logic errPrev = 1'b0;

  ps2_keyboard #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .iCLK     (clk),
    .iRST_n   (rst_n),
    .iPS2_CLK (ps2Clk),
    .iPS2_DAT (ps2Dat),
    .oKBD     (kbd),
    .oERR     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err) errPulses++;
    if (err && errPrev) errWide++;
    errPrev <= err;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: lookup tables keyed by scancode
  bit [7:0] loMap[bit [7:0]];
  bit [7:0] hiMap[bit [7:0]];
  bit [7:0] extMap[bit [7:0]];
  bit       isLetter[bit [7:0]];
  bit       mShift, mExt, mBrk, mCaps;
  bit [7:0] mKbd;

  task automatic buildTables();
    bit [7:0] letScan[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                              8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                              8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    bit [7:0] symScan[22] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45,
                              8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,
                              8'h4A,8'h29};
    bit [7:0] fScan[12]   = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,
                              8'h78,8'h07};
    bit [7:0] navScan[10] = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};
    bit [7:0] symLo[22]   = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h30,
                              8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,
                              8'h2F,8'h20};
    bit [7:0] symHi[22]   = '{8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28,8'h29,
                              8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,
                              8'h3F,8'h20};
    for (int i = 0; i < 26; i++) begin
      loMap[letScan[i]]    = 8'h61 + 8'(i);
      hiMap[letScan[i]]    = 8'h41 + 8'(i);
      isLetter[letScan[i]] = 1'b1;
    end
    for (int i = 0; i < 22; i++) begin
      loMap[symScan[i]] = symLo[i];
      hiMap[symScan[i]] = symHi[i];
    end
    for (int i = 0; i < 12; i++) begin
      loMap[fScan[i]] = 8'd141 + 8'(i);
      hiMap[fScan[i]] = 8'd141 + 8'(i);
    end
    loMap[8'h5A] = 8'd128; hiMap[8'h5A] = 8'd128;
    loMap[8'h66] = 8'd129; hiMap[8'h66] = 8'd129;
    loMap[8'h76] = 8'd140; hiMap[8'h76] = 8'd140;
    for (int i = 0; i < 10; i++) extMap[navScan[i]] = 8'd130 + 8'(i);
  endtask

  function automatic bit [7:0] lookup(bit e, bit s, bit c, bit [7:0] b);
    if (e) return extMap.exists(b) ? extMap[b] : 8'h00;
    if (!loMap.exists(b)) return 8'h00;
    if (isLetter.exists(b)) return (s ^ c) ? hiMap[b] : loMap[b];
    return s ? hiMap[b] : loMap[b];
  endfunction

  task automatic modelReset();
    mShift = 0; mExt = 0; mBrk = 0; mCaps = 0; mKbd = 8'h00;
  endtask

  task automatic modelByte(bit [7:0] b);
    bit [7:0] code, lo, hi;
    if (b == 8'hE0) mExt = 1;
    else if (b == 8'hF0) mBrk = 1;
    else begin
      if (b == 8'h12 || b == 8'h59) mShift = !mBrk;
`ifdef PS2_CAPSLOCK_EN
      else if (b == 8'h58) begin
        if (!mBrk) mCaps = !mCaps;
      end
`endif
      else if (!mBrk) begin
        code = lookup(mExt, mShift, mCaps, b);
        if (code != 8'h00) mKbd = code;
      end else begin
        lo = lookup(mExt, 1'b0, 1'b0, b);
        hi = lookup(mExt, 1'b1, 1'b0, b);
        if (mKbd != 8'h00 && (lo == mKbd || hi == mKbd)) mKbd = 8'h00;
      end
      mExt = 0; mBrk = 0;
    end
  endtask

  task automatic sendBit(bit v);
    ps2Dat = v;
    repeat (HALF/2) @(posedge clk);
    ps2Clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2Clk = 1'b1;
    repeat (HALF/2) @(posedge clk);
  endtask

  task automatic sendFrame(bit [7:0] b, bit badParity = 1'b0);
    bit [10:0] bits;
    bits = {1'b1, (~^b) ^ badParity, b, 1'b0};
    for (int i = 0; i < 11; i++) sendBit(bits[i]);
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendKey(bit [7:0] b);
    sendFrame(b);
    modelByte(b);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nChecks++;
    if (kbd !== 16'h0000) begin nFails++; $display("FAIL reset_kbd: got %h expected %h", kbd, 16'h0000); end
    nChecks++;
    if (err !== 1'b0) begin nFails++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    modelReset();
  endtask

  task automatic test_make_break();
    int e0 = errPulses;
    sendKey(8'h1C);
    nChecks++;
    if (kbd !== 16'h0061) begin nFails++; $display("FAIL make_a: got %h expected %h", kbd, 16'h0061); end
    sendKey(8'hF0); sendKey(8'h1C);
    nChecks++;
    if (kbd !== 16'h0000) begin nFails++; $display("FAIL break_a: got %h expected %h", kbd, 16'h0000); end
    nChecks++;
    if (errPulses !== e0) begin nFails++; $display("FAIL clean_err: got %0d expected %0d", errPulses, e0); end
  endtask

  task automatic test_shift();
    sendKey(8'h12); sendKey(8'h1C);
    nChecks++;
    if (kbd !== 16'h0041) begin nFails++; $display("FAIL shift_A: got %h expected %h", kbd, 16'h0041); end
    sendKey(8'hF0); sendKey(8'h12);
    nChecks++;
    if (kbd !== 16'h0041) begin nFails++; $display("FAIL shift_rel: got %h expected %h", kbd, 16'h0041); end
    sendKey(8'hF0); sendKey(8'h1C);
    nChecks++;
    if (kbd !== 16'h0000) begin nFails++; $display("FAIL shift_brk: got %h expected %h", kbd, 16'h0000); end
  endtask

  task automatic test_ext();
    sendKey(8'hE0); sendKey(8'h6B);
    nChecks++;
    if (kbd !== 16'd130) begin nFails++; $display("FAIL ext_left: got %h expected %h", kbd, 16'd130); end
    sendKey(8'h6B);
    nChecks++;
    if (kbd !== 16'd130) begin nFails++; $display("FAIL keypad4: got %h expected %h", kbd, 16'd130); end
    sendKey(8'hE0); sendKey(8'hF0); sendKey(8'h6B);
    nChecks++;
    if (kbd !== 16'h0000) begin nFails++; $display("FAIL ext_brk: got %h expected %h", kbd, 16'h0000); end
  endtask

  task automatic test_parity();
    int e0 = errPulses;
    sendFrame(8'h1C, 1'b1);
    nChecks++;
    if (errPulses !== e0 + 1) begin nFails++; $display("FAIL parity_err: got %0d expected %0d", errPulses, e0 + 1); end
    nChecks++;
    if (kbd !== 16'h0000) begin nFails++; $display("FAIL parity_kbd: got %h expected %h", kbd, 16'h0000); end
    sendKey(8'h1C);
    nChecks++;
    if (kbd !== 16'h0061) begin nFails++; $display("FAIL after_parity: got %h expected %h", kbd, 16'h0061); end
    sendKey(8'hF0); sendKey(8'h1C);
  endtask

  task automatic test_timeout();
    int e0 = errPulses;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    repeat (TIMEOUT_CYC + 50) @(posedge clk);
    @(negedge clk);
    nChecks++;
    if (errPulses !== e0 + 1) begin nFails++; $display("FAIL timeout_err: got %0d expected %0d", errPulses, e0 + 1); end
    sendKey(8'h1C);
    nChecks++;
    if (kbd !== 16'h0061) begin nFails++; $display("FAIL after_timeout: got %h expected %h", kbd, 16'h0061); end
  endtask

  task automatic test_reset_midframe();
    int e0;
    sendBit(1'b0);
    sendBit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (kbd !== 16'h0000) begin nFails++; $display("FAIL async_rst: got %h expected %h", kbd, 16'h0000); end
    modelReset();
    repeat (4) @(posedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    e0 = errPulses;
    ps2Dat = 1'b0;
    ps2Clk = 1'b0;
    repeat (FILTER_LEN - 2) @(posedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(posedge clk);
    ps2Dat = 1'b1;
    repeat (20) @(posedge clk);
    sendKey(8'h1C);
    nChecks++;
    if (kbd !== 16'h0061) begin nFails++; $display("FAIL glitch: got %h expected %h", kbd, 16'h0061); end
    nChecks++;
    if (errPulses !== e0) begin nFails++; $display("FAIL glitch_err: got %0d expected %0d", errPulses, e0); end
  endtask

  task automatic test_random();
    bit [7:0] pool[] = '{8'h1C,8'h32,8'h15,8'h1A,8'h16,8'h45,8'h4A,8'h52,8'h29,8'h5A,8'h66,8'h76,
                         8'h05,8'h07,8'h6B,8'h75,8'h71,8'h12,8'h59,8'h58,8'h0D,8'hE0,8'hF0,8'hF0};
    int e0 = errPulses;
    bit [7:0] b;
    for (int n = 0; n < 40; n++) begin
      b = pool[$urandom_range(pool.size() - 1)];
      sendKey(b);
      nChecks++;
      if (kbd !== {8'h00, mKbd}) begin
        nFails++;
        $display("FAIL random[%0d] byte %h: got %h expected %h", n, b, kbd, {8'h00, mKbd});
      end
    end
    nChecks++;
    if (errPulses !== e0) begin nFails++; $display("FAIL random_err: got %0d expected %0d", errPulses, e0); end
    nChecks++;
    if (errWide !== 0) begin nFails++; $display("FAIL err_width: got %0d expected %0d", errWide, 0); end
  endtask

  initial begin
    buildTables();
    modelReset();
    test_reset();
    test_make_break();
    test_shift();
    test_ext();
    test_parity();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
